// File: rtl/pe_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module     : pe_acc_pkg
// Description: Shared definitions for the product accumulator slice.
//              - Accumulator FSM state encoding.
//              - Default datapath widths.
//              - Result buffer depth.
//              Configuration macro used by this slice: PRODUCT_ACC_SATURATE_EN.
// Revision   : 1.0 - initial release
// ============================================================================
package pe_acc_pkg;

  // Accumulator FSM state encoding.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Default datapath widths.
  localparam int DEF_WIDTH_IN  = 48;
  localparam int DEF_WIDTH_ACC = 64;
  localparam int DEF_CNT_WIDTH = 10;

  // Depth of the result buffer between the accumulator and the write-back path.
  localparam int RESULT_BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module     : result_fifo
// Description: Small shift-register FIFO holding completed group sums.
//              The head entry is always at position 0, so data_out comes
//              straight from a flop.
//              Push and pop in the same cycle are accepted at any occupancy.
//              A push while full with no pop is ignored; the caller flags it.
// Ports      : clk      - clock, rising edge
//              reset_n  - asynchronous active-low reset
//              push     - write data_in this cycle
//              data_in  - entry to write
//              pop      - remove head entry (ignored when empty)
//              data_out - head entry
//              valid    - FIFO non-empty
//              count    - current occupancy
// Revision   : 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    base;
  logic             pop_eff;
  logic             push_eff;

  assign pop_eff  = pop && (count_r != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_eff = push && ((count_r != CW'(DEPTH)) || pop_eff);
  // Slot the new entry lands in, after the optional pop has shifted things.
  assign base     = pop_eff ? (count_r - CW'(1)) : count_r;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = mem[i+1];
    end
    shifted[DEPTH-1] = mem[DEPTH-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_eff && (base == CW'(i))) begin
          mem[i] <= data_in;
        end else if (pop_eff) begin
          mem[i] <= shifted[i];
        end
      end
      case ({push_eff, pop_eff})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign data_out = mem[0];
  assign valid    = (count_r != '0);
  assign count    = count_r;

endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module     : product_accumulator
// Description: Sums groups of num_terms unsigned products into a wide
//              accumulator and delivers each sum through a 2-entry result
//              buffer with a valid/ready handshake. almost_full lets the
//              multiplier gate its enable, since the product side has no
//              backpressure.
//              Optional build macro PRODUCT_ACC_SATURATE_EN: clamp the
//              accumulator to all-ones on overflow instead of wrapping.
// Ports      : clk         - clock, rising edge
//              reset_n     - asynchronous active-low reset
//              clear       - synchronous abort of the group in progress
//              num_terms   - products per group, sampled on first product
//              in_data     - product from the multiplier
//              in_valid    - in_data valid this cycle
//              out_data    - head of the result buffer
//              out_valid   - result buffer non-empty
//              out_ready   - consumer accepts out_data
//              almost_full - result buffer holds at least one entry
//              drop_err    - sticky: a completed sum was lost to a full buffer
// Revision   : 1.0 - initial release
// ============================================================================
module product_accumulator
  import pe_acc_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_ACC = DEF_WIDTH_ACC,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] num_terms,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_valid,
  output logic [WIDTH_ACC-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 almost_full,
  output logic                 drop_err
);

  localparam int FIFO_CW = $clog2(RESULT_BUF_DEPTH + 1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH_ACC-1:0] acc;
  logic [WIDTH_ACC-1:0] in_ext;
  logic [WIDTH_ACC:0]   raw_sum;
  logic [WIDTH_ACC-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] n_lat;
  logic [CNT_WIDTH-1:0] n_start;
  logic                 start;
  logic                 accum;
  logic                 complete;
  logic [WIDTH_ACC-1:0] complete_data;
  logic                 push_q;
  logic [WIDTH_ACC-1:0] push_data_q;
  logic [FIFO_CW-1:0]   fifo_count;

  // Zero-extend the product; the equal-width case needs no padding.
  if (WIDTH_ACC > WIDTH_IN) begin : g_ext
    assign in_ext = {{(WIDTH_ACC-WIDTH_IN){1'b0}}, in_data};
  end else begin : g_noext
    assign in_ext = in_data;
  end

  assign raw_sum = {1'b0, acc} + {1'b0, in_ext};

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once clamped, any further non-zero add carries out again, so the
  // accumulator holds all-ones until the group ends.
  assign sum = raw_sum[WIDTH_ACC] ? {WIDTH_ACC{1'b1}} : raw_sum[WIDTH_ACC-1:0];
`else
  assign sum = raw_sum[WIDTH_ACC-1:0];
`endif

  assign n_start = (num_terms == '0) ? CNT_WIDTH'(1) : num_terms;
  assign cnt_inc = cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // clear overrides any product arriving in the same cycle, which also
  // cancels a push that product would have completed.
  always_comb begin
    state_next    = state;
    start         = 1'b0;
    accum         = 1'b0;
    complete      = 1'b0;
    complete_data = sum;
    if (clear) begin
      state_next = IDLE;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          start = 1'b1;
          if (n_start == CNT_WIDTH'(1)) begin
            complete      = 1'b1;
            complete_data = in_ext;
          end else begin
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          accum = 1'b1;
          if (cnt_inc == n_lat) begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      cnt         <= '0;
      n_lat       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      drop_err    <= 1'b0;
    end else begin
      // Completed sums pass through one register stage before the buffer.
      push_q      <= complete;
      push_data_q <= complete_data;
      if (clear || complete) begin
        acc <= '0;
        cnt <= '0;
      end else if (start) begin
        acc   <= in_ext;
        cnt   <= CNT_WIDTH'(1);
        n_lat <= n_start;
      end else if (accum) begin
        acc <= sum;
        cnt <= cnt_inc;
      end
      if (push_q && (fifo_count == FIFO_CW'(RESULT_BUF_DEPTH)) && !out_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

  result_fifo #(
    .WIDTH (WIDTH_ACC),
    .DEPTH (RESULT_BUF_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_q),
    .data_in  (push_data_q),
    .pop      (out_ready),
    .data_out (out_data),
    .valid    (out_valid),
    .count    (fifo_count)
  );

  assign almost_full = (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module     : tb_product_accumulator
// Description: Directed self-checking bench for product_accumulator.
//              dut_a uses default widths; dut_b uses a 48-bit accumulator
//              to exercise wrap/saturation at the accumulator width.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic [9:0]  num_terms;
  logic [47:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic [63:0] out_data_a;
  logic        out_valid_a;
  logic        almost_full_a;
  logic        drop_err_a;

  logic [47:0] out_data_b;
  logic        out_valid_b;
  logic        almost_full_b;
  logic        drop_err_b;

  int compared;
  int mismatched;

  product_accumulator dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .num_terms   (num_terms),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready),
    .almost_full (almost_full_a),
    .drop_err    (drop_err_a)
  );

  product_accumulator #(
    .WIDTH_IN  (48),
    .WIDTH_ACC (48),
    .CNT_WIDTH (10)
  ) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .num_terms   (num_terms),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready),
    .almost_full (almost_full_b),
    .drop_err    (drop_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prod(input logic [47:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    clear      = 1'b0;
    num_terms  = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("rst_out_data", out_data_a, 64'd0);
    check("rst_almost_full", {63'd0, almost_full_a}, 64'd0);
    check("rst_drop_err", {63'd0, drop_err_a}, 64'd0);
    check("rst_b_valid", {63'd0, out_valid_b | almost_full_b | drop_err_b}, 64'd0);
    reset_n = 1'b1;
    tick();

    // T1: 1+2+3+4; num_terms changed mid-group must be ignored
    out_ready = 1'b1;
    num_terms = 10'd4;
    prod(48'd1);
    num_terms = 10'd1;
    prod(48'd2);
    prod(48'd3);
    prod(48'd4);
    in_valid = 1'b0;
    check("t1_latency", {63'd0, out_valid_a}, 64'd0);
    tick();
    check("t1_valid", {63'd0, out_valid_a}, 64'd1);
    check("t1_data", out_data_a, 64'd10);
    check("t1_almost_full", {63'd0, almost_full_a}, 64'd1);
    tick();
    check("t1_one_cycle", {63'd0, out_valid_a}, 64'd0);

    // T2: num_terms=0 behaves as 1, back-to-back groups
    num_terms = 10'd0;
    prod(48'd7);
    prod(48'd9);
    in_valid = 1'b0;
    check("t2_first_valid", {63'd0, out_valid_a}, 64'd1);
    check("t2_first_data", out_data_a, 64'd7);
    tick();
    check("t2_second_data", out_data_a, 64'd9);
    tick();
    check("t2_empty", {63'd0, out_valid_a}, 64'd0);

    // T3: buffer fills, third sum dropped, drain in order
    out_ready = 1'b0;
    num_terms = 10'd1;
    prod(48'd5);
    prod(48'd6);
    prod(48'd7);
    in_valid = 1'b0;
    check("t3_no_drop_yet", {63'd0, drop_err_a}, 64'd0);
    tick();
    check("t3_almost_full", {63'd0, almost_full_a}, 64'd1);
    check("t3_drop_err", {63'd0, drop_err_a}, 64'd1);
    check("t3_head_stable", out_data_a, 64'd5);
    tick();
    check("t3_hold_data", out_data_a, 64'd5);
    check("t3_hold_valid", {63'd0, out_valid_a}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("t3_drain_second", out_data_a, 64'd6);
    tick();
    check("t3_drained", {63'd0, out_valid_a}, 64'd0);
    check("t3_drop_sticky", {63'd0, drop_err_a}, 64'd1);

    // T4: clear aborts a group and discards the coincident product
    num_terms = 10'd3;
    prod(48'd2);
    prod(48'd3);
    clear = 1'b1;
    prod(48'd4);
    clear    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("t4_no_output_a", {63'd0, out_valid_a}, 64'd0);
    tick();
    check("t4_no_output_b", {63'd0, out_valid_a}, 64'd0);
    prod(48'd1);
    prod(48'd1);
    prod(48'd1);
    in_valid = 1'b0;
    tick();
    check("t4_valid", {63'd0, out_valid_a}, 64'd1);
    check("t4_data", out_data_a, 64'd3);
    tick();

    // T5: overflow at 48-bit accumulator width
    num_terms = 10'd2;
    prod(48'hFFFF_FFFF_FFFF);
    prod(48'd2);
    in_valid = 1'b0;
    tick();
    check("t5_wide_valid", {63'd0, out_valid_a}, 64'd1);
    check("t5_wide_data", out_data_a, 64'h0001_0000_0000_0001);
    check("t5_narrow_valid", {63'd0, out_valid_b}, 64'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
    check("t5_narrow_data", {16'd0, out_data_b}, 64'h0000_FFFF_FFFF_FFFF);
`else
    check("t5_narrow_data", {16'd0, out_data_b}, 64'd1);
`endif
    tick();

    // T6: asynchronous reset mid-group with one buffered result
    out_ready = 1'b0;
    num_terms = 10'd1;
    prod(48'd9);
    in_valid = 1'b0;
    tick();
    check("t6_buffered", {63'd0, out_valid_a}, 64'd1);
    check("t6_drop_before", {63'd0, drop_err_a}, 64'd1);
    num_terms = 10'd3;
    prod(48'd1);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", {63'd0, out_valid_a}, 64'd0);
    check("t6_async_drop", {63'd0, drop_err_a}, 64'd0);
    check("t6_async_af", {63'd0, almost_full_a}, 64'd0);
    #1;
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    num_terms = 10'd2;
    prod(48'd3);
    prod(48'd4);
    in_valid = 1'b0;
    tick();
    check("t6_valid", {63'd0, out_valid_a}, 64'd1);
    check("t6_data", out_data_a, 64'd7);
    tick();
    check("t6_empty", {63'd0, out_valid_a}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
